// File: rtl/bus_timer_slave_pkg.sv
// Shared bus definitions: transfer modes, slot selects, timer register map.
// Optional feature macro used by this slice: TMR_PRESCALE_EN.
package bus_timer_slave_pkg;

  // Master transfer mode encodings (MmMOD)
  typedef enum logic [2:0] {
    MOD_IDLE      = 3'b000,
    MOD_BUSY      = 3'b001,
    MOD_LDADDR    = 3'b010,
    MOD_SEQADDR   = 3'b011,
    MOD_LDWRPADDR = 3'b110,
    MOD_WRPADDR   = 3'b111
  } mmmod_e;

  // Bus response FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } bus_st_e;

  // Decoder slot constants
  localparam int unsigned SLOT_TIMER_BIT = 3;
  localparam logic [15:0] SLOT_TIMER     = 16'h0008;

  // Timer register offsets
  localparam logic [11:0] OFS_CTRL  = 12'h000;
  localparam logic [11:0] OFS_LOAD  = 12'h004;
  localparam logic [11:0] OFS_COUNT = 12'h008;
  localparam logic [11:0] OFS_STAT  = 12'h00C;
  localparam logic [11:0] OFS_PRESC = 12'h010;

  // CTRL bit positions
  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  // IDLE and BUSY are the only modes with bit 1 clear; all others move data
  function automatic logic is_xfer(input logic [2:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/bus_timer_slave_tmr_core.sv
// Timer core: LOAD, down-counter with auto-reload, EXP flag.
// TMR_PRESCALE_EN adds the PRESC register and a 16-bit prescaler.
module tmr_core (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_en_rise,
  input  logic        i_load_we,
  input  logic        i_w1c,
  input  logic [31:0] i_wdata,
`ifdef TMR_PRESCALE_EN
  input  logic        i_presc_we,
  output logic [15:0] o_presc,
`endif
  output logic [31:0] o_load,
  output logic [31:0] o_count,
  output logic        o_exp
);

  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_exp;
  logic        w_tick;

`ifdef TMR_PRESCALE_EN
  logic [15:0] r_presc;
  logic [15:0] r_psc_cnt;

  // >= rather than == so that lowering PRESC mid-count still ticks promptly
  assign w_tick  = i_en & (r_psc_cnt >= r_presc);
  assign o_presc = r_presc;

  // Prescale terminal value register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)        r_presc <= '0;
    else if (i_presc_we) r_presc <= i_wdata[15:0];
  end

  // Prescaler counter: restarts on enable and after every tick
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                   r_psc_cnt <= '0;
    else if (i_en_rise || w_tick)   r_psc_cnt <= '0;
    else if (i_en)                  r_psc_cnt <= r_psc_cnt + 16'd1;
  end
`else
  assign w_tick = i_en;
`endif

  // Reload value register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_load <= '0;
    else if (i_load_we) r_load <= i_wdata;
  end

  // Down-counter: copy LOAD on enable, auto-reload (old LOAD) on expiry
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)         r_count <= '0;
    else if (i_en_rise)   r_count <= r_load;
    else if (w_tick) begin
      if (r_count == '0)  r_count <= r_load;
      else                r_count <= r_count - 32'd1;
    end
  end

  // Expiry flag: setting takes priority over write-one-to-clear
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                       r_exp <= 1'b0;
    else if (w_tick && r_count == '0)   r_exp <= 1'b1;
    else if (i_w1c)                     r_exp <= 1'b0;
  end

  assign o_load  = r_load;
  assign o_count = r_count;
  assign o_exp   = r_exp;

endmodule

// File: rtl/bus_timer_slave.sv
// Core-bus Timer slave: address/data phase FSM, register decode, timer core.
// TMR_PRESCALE_EN adds PRESC at offset 0x10 (otherwise 0x10 returns an error).
module bus_timer_slave #(
  parameter int unsigned WAIT_CYC   = 1,
  parameter int unsigned WRAP_BYTES = 16,
  parameter int unsigned SEL_BIT    = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [15:0] DxSEL,
  input  logic [31:0] MmADDR,
  input  logic [2:0]  MmMOD,
  input  logic        MmWR,
  input  logic [31:0] MmWDT,
  input  logic        BxRDY,
  output logic        MsRDY,
  output logic        MsERR,
  output logic [31:0] MsRDT,
  output logic        TmrIRQ
);
  import bus_timer_slave_pkg::*;

  localparam logic [2:0]  WAIT_INIT = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);
  localparam logic [11:0] WMASK     = 12'(WRAP_BYTES - 1);
`ifdef TMR_PRESCALE_EN
  localparam logic [11:0] OFS_LIMIT = 12'h014;
`else
  localparam logic [11:0] OFS_LIMIT = 12'h010;
`endif

  bus_st_e     r_state, w_state_nxt;
  logic [2:0]  r_wcnt, w_wcnt_nxt;
  logic [11:0] r_offset;
  logic        r_wr;
  logic [1:0]  r_ctrl;

  logic        w_accept;
  logic [11:0] w_seq, w_wrp;
  logic        w_err, w_commit;
  logic        w_ctrl_we, w_en_rise, w_load_we, w_w1c;
  logic [31:0] w_rdata, w_load, w_count;
  logic        w_exp;
  logic        w_unused_bits;

  assign w_unused_bits = ^{DxSEL, MmADDR[31:12]};

  assign w_accept = BxRDY & DxSEL[SEL_BIT] & is_xfer(MmMOD) & (r_state != ST_WAIT);
  assign w_seq    = r_offset + 12'd4;
  assign w_wrp    = (r_offset & ~WMASK) | (w_seq & WMASK);

  assign w_err    = (r_offset[1:0] != 2'b00) | (r_offset >= OFS_LIMIT)
                  | (r_wr & (r_offset == OFS_COUNT));
  assign w_commit = (r_state == ST_RESP) & r_wr & ~w_err;

  assign w_ctrl_we = w_commit & (r_offset == OFS_CTRL);
  assign w_en_rise = w_ctrl_we & MmWDT[CTRL_EN] & ~r_ctrl[CTRL_EN];
  assign w_load_we = w_commit & (r_offset == OFS_LOAD);
  assign w_w1c     = w_commit & (r_offset == OFS_STAT) & MmWDT[0];

  // Address-phase capture: offset update by transfer mode, direction
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_offset <= '0;
      r_wr     <= 1'b0;
    end else if (w_accept) begin
      r_wr <= MmWR;
      unique case (MmMOD)
        MOD_SEQADDR: r_offset <= w_seq;
        MOD_WRPADDR: r_offset <= w_wrp;
        default:     r_offset <= MmADDR[11:0];
      endcase
    end
  end

  // FSM state and wait-state counter registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Next-state: a new accept in IDLE or RESP opens a data phase
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    unique case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          if (WAIT_CYC == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_wcnt_nxt  = WAIT_INIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_wcnt == '0) w_state_nxt = ST_RESP;
        else              w_wcnt_nxt  = r_wcnt - 3'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // CTRL register {IE, EN}
  always_ff @(posedge CLK) begin
    if (!nRST)          r_ctrl <= '0;
    else if (w_ctrl_we) r_ctrl <= MmWDT[1:0];
  end

`ifdef TMR_PRESCALE_EN
  logic        w_presc_we;
  logic [15:0] w_presc;
  assign w_presc_we = w_commit & (r_offset == OFS_PRESC);
`endif

  tmr_core u_tmr (
    .i_clk      (CLK),
    .i_rst_n    (nRST),
    .i_en       (r_ctrl[CTRL_EN]),
    .i_en_rise  (w_en_rise),
    .i_load_we  (w_load_we),
    .i_w1c      (w_w1c),
    .i_wdata    (MmWDT),
`ifdef TMR_PRESCALE_EN
    .i_presc_we (w_presc_we),
    .o_presc    (w_presc),
`endif
    .o_load     (w_load),
    .o_count    (w_count),
    .o_exp      (w_exp)
  );

  // Register read mux
  always_comb begin
    w_rdata = '0;
    unique case (r_offset)
      OFS_CTRL:  w_rdata = {30'd0, r_ctrl};
      OFS_LOAD:  w_rdata = w_load;
      OFS_COUNT: w_rdata = w_count;
      OFS_STAT:  w_rdata = {31'd0, w_exp};
`ifdef TMR_PRESCALE_EN
      OFS_PRESC: w_rdata = {16'd0, w_presc};
`endif
      default:   w_rdata = '0;
    endcase
  end

  // Bus response outputs: ready except in wait states, data/error only in RESP
  always_comb begin
    MsRDY  = (r_state != ST_WAIT);
    MsERR  = 1'b0;
    MsRDT  = '0;
    TmrIRQ = w_exp & r_ctrl[CTRL_IE];
    if (r_state == ST_RESP) begin
      MsERR = w_err;
      if (!r_wr && !w_err) MsRDT = w_rdata;
    end
  end

endmodule
